// File: rtl/cursor_position.sv
`default_nettype none
// ============================================================================
// Module   : cursor_position
// Brief    : Terminal cursor row/column registers. Executes movement commands
//            from the escape/control decoder, raises scroll requests toward
//            screen memory and pulses pos_changed whenever the cursor moves.
// Options  : CURSOR_AUTO_WRAP_EN - ADVANCE at the last column wraps to column
//            0 of the next line (scrolling at the bottom row). When undefined,
//            the cursor sticks at the last column (VT52 behaviour).
// Revision : 1.0 - initial release
// ============================================================================
module cursor_position #(
    parameter int COLS     = 80,
    parameter int ROWS     = 24,
    parameter int COL_W    = 7,
    parameter int ROW_W    = 5,
    parameter int TAB_STOP = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cmd_valid,
    input  logic [3:0]       cmd,
    input  logic [ROW_W-1:0] cmd_row,
    input  logic [COL_W-1:0] cmd_col,
    output logic             cmd_ready,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             pos_changed,
    output logic             scroll_req,
    output logic             scroll_dir,
    input  logic             scroll_ack
);

    // Opcodes from the decoder; 12-15 fall into the default (NOP) arm.
    localparam logic [3:0] c_op_up      = 4'd1;
    localparam logic [3:0] c_op_down    = 4'd2;
    localparam logic [3:0] c_op_right   = 4'd3;
    localparam logic [3:0] c_op_left    = 4'd4;
    localparam logic [3:0] c_op_home    = 4'd5;
    localparam logic [3:0] c_op_cr      = 4'd6;
    localparam logic [3:0] c_op_lf      = 4'd7;
    localparam logic [3:0] c_op_advance = 4'd8;
    localparam logic [3:0] c_op_addr    = 4'd9;
    localparam logic [3:0] c_op_tab     = 4'd10;
    localparam logic [3:0] c_op_rlf     = 4'd11;

    localparam logic [ROW_W-1:0] c_row_max   = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] c_row_one   = ROW_W'(1);
    localparam logic [COL_W-1:0] c_col_max   = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0] c_col_one   = COL_W'(1);
    localparam logic [COL_W-1:0] c_tab_stop  = COL_W'(TAB_STOP);
    localparam logic [COL_W-1:0] c_tab_limit = COL_W'(COLS - TAB_STOP);

    typedef enum logic [0:0] {
        IDLE        = 1'b0,
        SCROLL_WAIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             pos_changed_q, pos_changed_d;
    logic             scroll_dir_q, scroll_dir_d;

    logic             w_accept;
    logic [COL_W-1:0] w_tab_next;

    assign cmd_ready   = (state_q == IDLE);
    assign w_accept    = cmd_valid && cmd_ready;
    // scroll_req follows the state directly so an async clear drops it at once.
    assign scroll_req  = (state_q == SCROLL_WAIT);
    assign scroll_dir  = scroll_dir_q;
    assign row         = row_q;
    assign col         = col_q;
    assign pos_changed = pos_changed_q;

    // Next tab stop; only used when col < COLS-TAB_STOP so it never overflows.
    assign w_tab_next = (col_q / c_tab_stop + c_col_one) * c_tab_stop;

    // State and cursor registers with asynchronous clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q       <= IDLE;
            row_q         <= '0;
            col_q         <= '0;
            pos_changed_q <= 1'b0;
            scroll_dir_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            pos_changed_q <= pos_changed_d;
            scroll_dir_q  <= scroll_dir_d;
        end
    end

    // Command execution, scroll handshake and move detection.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        scroll_dir_d = scroll_dir_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd)
                        c_op_up:    if (row_q != '0)        row_d = row_q - c_row_one;
                        c_op_down:  if (row_q < c_row_max)  row_d = row_q + c_row_one;
                        c_op_right: if (col_q < c_col_max)  col_d = col_q + c_col_one;
                        c_op_left:  if (col_q != '0)        col_d = col_q - c_col_one;
                        c_op_home: begin
                            row_d = '0;
                            col_d = '0;
                        end
                        c_op_cr:    col_d = '0;
                        c_op_lf: begin
                            if (row_q < c_row_max) begin
                                row_d = row_q + c_row_one;
                            end else begin
                                state_d      = SCROLL_WAIT;
                                scroll_dir_d = 1'b0;
                            end
                        end
                        c_op_rlf: begin
                            if (row_q != '0) begin
                                row_d = row_q - c_row_one;
                            end else begin
                                state_d      = SCROLL_WAIT;
                                scroll_dir_d = 1'b1;
                            end
                        end
                        c_op_advance: begin
                            if (col_q < c_col_max) begin
                                col_d = col_q + c_col_one;
                            end else begin
`ifdef CURSOR_AUTO_WRAP_EN
                                col_d = '0;
                                if (row_q < c_row_max) begin
                                    row_d = row_q + c_row_one;
                                end else begin
                                    state_d      = SCROLL_WAIT;
                                    scroll_dir_d = 1'b0;
                                end
`endif
                            end
                        end
                        c_op_addr: begin
                            if (cmd_row <= c_row_max) row_d = cmd_row;
                            col_d = (cmd_col <= c_col_max) ? cmd_col : c_col_max;
                        end
                        c_op_tab: begin
                            if (col_q < c_tab_limit)     col_d = w_tab_next;
                            else if (col_q < c_col_max)  col_d = col_q + c_col_one;
                        end
                        default: ;
                    endcase
                end
            end
            SCROLL_WAIT: begin
                if (scroll_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        pos_changed_d = w_accept && ((row_d != row_q) || (col_d != col_q));
    end

endmodule
`default_nettype wire
